// File: rtl/chi_txreq_link.sv
// CHI REQ channel link-layer transmitter: queues request flits, spends L-credits,
// drives the TXLINKACTIVE handshake and returns unused credits on deactivation.
package chi_flit_pkg;
    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgtid;
        logic [6:0]  srcid;
        logic [7:0]  txnid;
        logic [5:0]  opcode;
        logic [2:0]  size;
        logic [43:0] addr;
    } reqflit_t;
endpackage

module chi_txreq_link
    import chi_flit_pkg::*;
#(
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned MAX_CREDITS = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        link_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  reqflit_t    req_flit,
    output logic        txlinkactivereq,
    input  logic        txlinkactiveack,
    output logic        txreqflitpend,
    output logic        txreqflitv,
    output reqflit_t    txreqflit,
    input  logic        txreqlcrdv,
    output logic [3:0]  credit_cnt,
    output logic        credit_overflow
);
    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CMAX = CW'(MAX_CREDITS);

    typedef enum logic [1:0] {ST_STOP, ST_ACT, ST_RUN, ST_DEACT} state_t;

    state_t      state;
    reqflit_t    mem [QDEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        pend_q;
    logic        empty;
    logic        full;
    logic        push;
    logic        grant;
    logic        send_data;
    logic        send_ret;
    logic        sent;
    reqflit_t    ret_flit;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign req_ready     = !full && (state == ST_RUN) && link_en;
    assign push          = req_valid && req_ready;
    assign txreqflitpend = (state == ST_RUN) || (state == ST_DEACT);

    // Credits only arrive from the receiver once activation has been requested.
    assign grant     = txreqlcrdv && (state != ST_STOP);
    assign send_data = (state == ST_RUN) && pend_q && (credit_cnt != '0) && !empty;
    assign send_ret  = (state == ST_DEACT) && pend_q && (credit_cnt != '0);
    assign sent      = send_data || send_ret;

    // Credit-return flit: everything zero except the routing IDs of the last flit.
    always_comb begin
        ret_flit       = '0;
        ret_flit.tgtid = txreqflit.tgtid;
        ret_flit.srcid = txreqflit.srcid;
    end

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= req_flit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_STOP;
            txlinkactivereq <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            pend_q          <= 1'b0;
            txreqflitv      <= 1'b0;
            txreqflit       <= '0;
            credit_cnt      <= '0;
            credit_overflow <= 1'b0;
        end else begin
            pend_q     <= txreqflitpend;
            txreqflitv <= sent;
            if (send_data) begin
                txreqflit <= mem[rd_ptr[AW-1:0]];
            end else if (send_ret) begin
                txreqflit <= ret_flit;
            end

            if (grant && !sent) begin
                if (credit_cnt == CMAX) begin
                    credit_overflow <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + CW'(1);
                end
            end else if (!grant && sent) begin
                credit_cnt <= credit_cnt - CW'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (send_data) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end

            // Link state machine; entering STOP flushes the queue.
            case (state)
                ST_STOP: begin
                    if (link_en) begin
                        state           <= ST_ACT;
                        txlinkactivereq <= 1'b1;
                    end
                end
                ST_ACT: begin
                    if (txlinkactiveack) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!link_en && empty) begin
                        state           <= ST_DEACT;
                        txlinkactivereq <= 1'b0;
                    end
                end
                ST_DEACT: begin
                    if ((credit_cnt == '0) && !txlinkactiveack) begin
                        state  <= ST_STOP;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                default: begin
                    state           <= ST_STOP;
                    txlinkactivereq <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chi_txreq_link.sv
// Scoreboard bench for chi_txreq_link: directed stimulus pushes expected flits,
// a negedge monitor pops and compares every txreqflitv.
module tb_chi_txreq_link;
    import chi_flit_pkg::*;

    logic        clock;
    logic        reset;
    logic        link_en;
    logic        req_valid;
    logic        req_ready;
    reqflit_t    req_flit;
    logic        txlinkactivereq;
    logic        txlinkactiveack;
    logic        txreqflitpend;
    logic        txreqflitv;
    reqflit_t    txreqflit;
    logic        txreqlcrdv;
    logic [3:0]  credit_cnt;
    logic        credit_overflow;

    chi_txreq_link #(.QDEPTH(4), .MAX_CREDITS(15)) dut (
        .clock           (clock),
        .reset           (reset),
        .link_en         (link_en),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_flit        (req_flit),
        .txlinkactivereq (txlinkactivereq),
        .txlinkactiveack (txlinkactiveack),
        .txreqflitpend   (txreqflitpend),
        .txreqflitv      (txreqflitv),
        .txreqflit       (txreqflit),
        .txreqlcrdv      (txreqlcrdv),
        .credit_cnt      (credit_cnt),
        .credit_overflow (credit_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    int       sent_cyc [256];
    logic     prev_pend = 1'b0;
    reqflit_t sb [$];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({req_ready, txlinkactivereq, txreqflitpend, txreqflitv,
                     txreqflit, credit_cnt, credit_overflow});
    endfunction

    function automatic reqflit_t mkflit(input logic [7:0] id, input logic [6:0] tgt, input logic [6:0] src);
        reqflit_t f;
        f        = '0;
        f.qos    = 4'h3;
        f.tgtid  = tgt;
        f.srcid  = src;
        f.txnid  = id;
        f.opcode = 6'h04;
        f.size   = 3'd6;
        f.addr   = 44'h1000 + (44'(id) << 6);
        return f;
    endfunction

    // Monitor: every presented flit must be expected, in order, and follow a pending cycle.
    always @(negedge clock) begin
        reqflit_t e;
        if (!reset && txreqflitv) begin
            check("pend_before_flitv", 128'(prev_pend), 128'(1));
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_flit: got %h expected none (cycle %0d)", txreqflit, cyc);
            end else begin
                e = sb.pop_front();
                check("flit", 128'(txreqflit), 128'(e));
                sent_cyc[txreqflit.txnid] = cyc;
            end
        end
        prev_pend = txreqflitpend;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic lcrd(input int n);
        txreqlcrdv = 1'b1;
        idle(n);
        txreqlcrdv = 1'b0;
    endtask

    task automatic push_flit(input reqflit_t f);
        bit hs;
        hs        = 1'b0;
        req_valid = 1'b1;
        req_flit  = f;
        sb.push_back(f);
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clock);
            hs = req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        if (!hs) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: txnid %0d got ready=0 expected ready=1", f.txnid);
        end
    endtask

    task automatic wait_req(input logic lvl);
        for (int i = 0; i < 20 && txlinkactivereq !== lvl; i++) idle(1);
        check("req_level", 128'(txlinkactivereq), 128'(lvl));
    endtask

    task automatic wait_sb_empty(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) idle(1);
        check("sb_drain", 128'(sb.size()), 128'(0));
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        link_en         = 1'b0;
        txlinkactiveack = 1'b0;
        txreqlcrdv      = 1'b0;
        req_valid       = 1'b0;
        idle(3);
        reset = 1'b0;
    endtask

    task automatic bring_up(input int ncred);
        link_en = 1'b1;
        wait_req(1'b1);
        txlinkactiveack = 1'b1;
        idle(2);
        lcrd(ncred);
        idle(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reqflit_t r;
        req_flit = '0;
        do_reset();

        // Idle after reset: everything quiet.
        for (int i = 0; i < 20; i++) begin
            check("idle_outputs", outs(), 128'(0));
            idle(1);
        end

        // Bring-up with three credits.
        bring_up(3);
        check("bringup_credit", 128'(credit_cnt), 128'(3));
        check("bringup_run", 128'({txlinkactivereq, txreqflitpend, txreqflitv, req_ready}), 128'(4'b1101));

        // Five flits, three credits: first three go out back to back.
        for (int i = 1; i <= 5; i++) push_flit(mkflit(8'(i), 7'h12, 7'h34));
        idle(6);
        check("credit_after_3", 128'(credit_cnt), 128'(0));
        check("sb_pending_2", 128'(sb.size()), 128'(2));
        check("consec_1_2", 128'(sent_cyc[2] - sent_cyc[1]), 128'(1));
        check("consec_2_3", 128'(sent_cyc[3] - sent_cyc[2]), 128'(1));
        lcrd(2);
        wait_sb_empty(20);
        check("credit_after_5", 128'(credit_cnt), 128'(0));

        // Fill the queue with no credits, then stream while lcrdv is held.
        for (int i = 11; i <= 14; i++) push_flit(mkflit(8'(i), 7'h12, 7'h34));
        check("full_not_ready", 128'(req_ready), 128'(0));
        txreqlcrdv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("credit_stream", 128'(credit_cnt), 128'((i == 0) ? 0 : 1));
            idle(1);
        end
        txreqlcrdv = 1'b0;
        wait_sb_empty(20);
        check("credit_stream_end", 128'(credit_cnt), 128'(1));
        check("stream_consec", 128'(sent_cyc[14] - sent_cyc[11]), 128'(3));

        // Overflow: 1 + 16 grants saturates at 15.
        lcrd(16);
        idle(1);
        check("ovf_credit", 128'(credit_cnt), 128'(15));
        check("ovf_flag", 128'(credit_overflow), 128'(1));
        idle(5);
        check("ovf_sticky", 128'({credit_overflow, credit_cnt}), 128'({1'b1, 4'd15}));

        do_reset();
        check("reset_outputs", outs(), 128'(0));

        // Deactivation with four credits held returns four zero-opcode flits.
        bring_up(5);
        push_flit(mkflit(8'd21, 7'h2a, 7'h15));
        wait_sb_empty(20);
        check("deact_credit_start", 128'(credit_cnt), 128'(4));
        r       = '0;
        r.tgtid = 7'h2a;
        r.srcid = 7'h15;
        for (int i = 0; i < 4; i++) sb.push_back(r);
        link_en = 1'b0;
        wait_req(1'b0);
        wait_sb_empty(20);
        check("deact_credit_end", 128'(credit_cnt), 128'(0));
        idle(3);
        check("deact_hold", 128'({txlinkactivereq, txreqflitpend, txreqflitv}), 128'(3'b010));
        txlinkactiveack = 1'b0;
        idle(2);
        check("stop_outputs", 128'({req_ready, txlinkactivereq, txreqflitpend, txreqflitv,
                                    credit_cnt, credit_overflow}), 128'(0));

        // Reset pulse in the first DEACT cycle: nothing returned, all outputs clear.
        bring_up(3);
        link_en = 1'b0;
        idle(1);
        check("mid_deact_state", 128'({txlinkactivereq, txreqflitpend}), 128'(2'b01));
        reset = 1'b1;
        txlinkactiveack = 1'b0;
        idle(2);
        reset = 1'b0;
        check("mid_deact_reset", outs(), 128'(0));

        idle(5);
        check("sb_final_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
